// File: rtl/hwregs_uart_multi.sv
// hwregs_uart_multi
// -----------------
// Hardware-register block for NUM_UARTS independent UART channels, mapped into
// a 64 KB register window. Each channel owns a TX FIFO (CPU -> UART) and an RX
// FIFO (UART -> CPU), sticky overflow flags and a 3-bit interrupt enable. All
// enabled and pending sources are ORed into a single registered level IRQ.
//
// Ports:
//   clock, reset_n          system clock (rising edge), async active-low reset
//   request/address/write/  single-cycle CPU bus request; byte address within
//   wstrb/wdata             the window, write flag, byte strobes, write data
//   rdata, ack              registered read data and acknowledge (1 cycle later)
//   uart_rx_complete/_data  per-channel RX byte strobe and byte (8 bits/channel)
//   uart_tx_valid/_data     per-channel TX FIFO not empty and its head byte
//   uart_tx_complete        per-channel pulse: head byte sent, pop TX FIFO
//   irq                     OR of all enabled pending interrupt sources
//
// Register map (channel n base = 0x0100 + n*0x10):
//   0x0000 IRQ_STATUS  R   bit n = channel n interrupt pending
//   +0x0   TX          W   push wdata[7:0] (wstrb[0]); R = slots free
//   +0x4   RX          R   pop head {24'h0, byte}; 0xFFFFFFFF when empty
//   +0x8   STATUS      R   {rx_count@16, tx_ovf, tx_empty, rx_ovf, tx_full,
//                          rx_not_empty}; W1C bits 2 and 4 (wstrb[0])
//   +0xC   IRQ_EN      RW  bits[2:0]: rx_not_empty, tx_empty, any overflow

module hwregs_uart_multi #(
  parameter int NUM_UARTS  = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   request,
  input  logic [15:0]            address,
  input  logic                   write,
  input  logic [3:0]             wstrb,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ack,
  input  logic [NUM_UARTS-1:0]   uart_rx_complete,
  input  logic [8*NUM_UARTS-1:0] uart_rx_data,
  output logic [NUM_UARTS-1:0]   uart_tx_valid,
  output logic [8*NUM_UARTS-1:0] uart_tx_data,
  input  logic [NUM_UARTS-1:0]   uart_tx_complete,
  output logic                   irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Register offsets inside a channel's 16-byte slot (address[3:2]).
  localparam logic [1:0] REG_TX     = 2'd0;
  localparam logic [1:0] REG_RX     = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  // --------------------------------------------------------------------------
  // Address decode shared by all channels
  // --------------------------------------------------------------------------
  logic       rd_req;
  logic       wr_req;
  logic       chan_window;
  logic       global_sel;
  logic [1:0] reg_sel;

  assign rd_req      = request && !write;
  assign wr_req      = request && write;
  // Channel slots live in 0x01x0..0x01xC; unaligned offsets are treated as unmapped.
  assign chan_window = (address[15:8] == 8'h01) && (address[1:0] == 2'b00);
  assign global_sel  = (address == 16'h0000);
  assign reg_sel     = address[3:2];

  logic [NUM_UARTS-1:0] pend;
  logic [31:0]          chan_rdata [NUM_UARTS];

  // --------------------------------------------------------------------------
  // Per-channel FIFOs and registers
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_UARTS; gi++) begin : g_chan
    logic          ch_hit;
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr_reg, tx_rptr_reg, rx_wptr_reg, rx_rptr_reg;
    logic [CW-1:0] tx_count_reg, rx_count_reg;
    logic [CW-1:0] tx_count_next, rx_count_next;
    logic          tx_ovf_reg, rx_ovf_reg;
    logic [2:0]    irq_en_reg;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push_req, tx_push, tx_pop, tx_ovf_set;
    logic rx_push, rx_pop, rx_ovf_set;
    logic status_w1c, irq_en_wr;
    logic [2:0]  src;
    logic [31:0] status_val;

    assign ch_hit   = chan_window && (address[7:4] == 4'(gi));

    assign tx_full  = (tx_count_reg == DEPTH_C);
    assign tx_empty = (tx_count_reg == '0);
    assign rx_full  = (rx_count_reg == DEPTH_C);
    assign rx_empty = (rx_count_reg == '0);

    // TX: a push while full is accepted only if the UART frees a slot in the
    // same cycle; otherwise the byte is dropped and the overflow flag set.
    assign tx_push_req = wr_req && ch_hit && (reg_sel == REG_TX) && wstrb[0];
    assign tx_pop      = uart_tx_complete[gi] && !tx_empty;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_ovf_set  = tx_push_req && tx_full && !tx_pop;

    // RX: same rule with the CPU read as the pop side.
    assign rx_pop      = rd_req && ch_hit && (reg_sel == REG_RX) && !rx_empty;
    assign rx_push     = uart_rx_complete[gi] && (!rx_full || rx_pop);
    assign rx_ovf_set  = uart_rx_complete[gi] && rx_full && !rx_pop;

    assign status_w1c  = wr_req && ch_hit && (reg_sel == REG_STATUS) && wstrb[0];
    assign irq_en_wr   = wr_req && ch_hit && (reg_sel == REG_IRQ_EN) && wstrb[0];

    always_comb begin
      tx_count_next = tx_count_reg;
      if (tx_push && !tx_pop)      tx_count_next = tx_count_reg + 1'b1;
      else if (!tx_push && tx_pop) tx_count_next = tx_count_reg - 1'b1;
    end

    always_comb begin
      rx_count_next = rx_count_reg;
      if (rx_push && !rx_pop)      rx_count_next = rx_count_reg + 1'b1;
      else if (!rx_push && rx_pop) rx_count_next = rx_count_reg - 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        tx_wptr_reg  <= '0;
        tx_rptr_reg  <= '0;
        tx_count_reg <= '0;
        rx_wptr_reg  <= '0;
        rx_rptr_reg  <= '0;
        rx_count_reg <= '0;
        tx_ovf_reg   <= 1'b0;
        rx_ovf_reg   <= 1'b0;
        irq_en_reg   <= 3'b000;
      end else begin
        if (tx_push) tx_wptr_reg <= tx_wptr_reg + 1'b1;
        if (tx_pop)  tx_rptr_reg <= tx_rptr_reg + 1'b1;
        if (rx_push) rx_wptr_reg <= rx_wptr_reg + 1'b1;
        if (rx_pop)  rx_rptr_reg <= rx_rptr_reg + 1'b1;
        tx_count_reg <= tx_count_next;
        rx_count_reg <= rx_count_next;
        // A new overflow event in the clearing cycle keeps the flag set.
        if (tx_ovf_set)                    tx_ovf_reg <= 1'b1;
        else if (status_w1c && wdata[4])   tx_ovf_reg <= 1'b0;
        if (rx_ovf_set)                    rx_ovf_reg <= 1'b1;
        else if (status_w1c && wdata[2])   rx_ovf_reg <= 1'b0;
        if (irq_en_wr) irq_en_reg <= wdata[2:0];
      end
    end

    // Storage is not reset; only the pointers and counts define its contents.
    always_ff @(posedge clock) begin
      if (tx_push) tx_mem[tx_wptr_reg] <= wdata[7:0];
      if (rx_push) rx_mem[rx_wptr_reg] <= uart_rx_data[8*gi +: 8];
    end

    // Head byte is forced to 0 while empty so the output is defined from reset.
    assign uart_tx_valid[gi]       = !tx_empty;
    assign uart_tx_data[8*gi +: 8] = tx_empty ? 8'h00 : tx_mem[tx_rptr_reg];

    assign src      = {rx_ovf_reg | tx_ovf_reg, tx_empty, !rx_empty};
    assign pend[gi] = |(irq_en_reg & src);

    always_comb begin
      status_val = 32'h0;
      status_val[0] = !rx_empty;
      status_val[1] = tx_full;
      status_val[2] = rx_ovf_reg;
      status_val[3] = tx_empty;
      status_val[4] = tx_ovf_reg;
      status_val[16 +: CW] = rx_count_reg;
    end

    always_comb begin
      chan_rdata[gi] = 32'h0;
      if (ch_hit) begin
        case (reg_sel)
          REG_TX:     chan_rdata[gi][CW-1:0] = DEPTH_C - tx_count_reg;
          REG_RX:     chan_rdata[gi] = rx_empty ? 32'hFFFF_FFFF
                                                : {24'h0, rx_mem[rx_rptr_reg]};
          REG_STATUS: chan_rdata[gi] = status_val;
          default:    chan_rdata[gi] = {29'h0, irq_en_reg};
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read mux, bus response and interrupt output
  // --------------------------------------------------------------------------
  logic [31:0] rd_mux;

  // At most one channel decodes a given address, so an OR mux is sufficient.
  always_comb begin
    rd_mux = global_sel ? 32'(pend) : 32'h0;
    for (int i = 0; i < NUM_UARTS; i++) begin
      rd_mux = rd_mux | chan_rdata[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack   <= 1'b0;
      rdata <= 32'h0;
      irq   <= 1'b0;
    end else begin
      ack   <= request;
      rdata <= rd_req ? rd_mux : 32'h0;
      irq   <= |pend;
    end
  end

  // Write-data bits and strobes that no register uses.
  logic unused_bits;
  assign unused_bits = ^{wdata[31:8], wstrb[3:1]};

endmodule

// File: tb/tb_hwregs_uart_multi.sv
// Self-checking bench for hwregs_uart_multi (2 channels, 16-deep FIFOs).
// Every bus request pushes its expected rdata onto a scoreboard queue; a
// monitor pops and compares on each ack. Scenario tasks check the UART-side
// outputs and irq inline.

module tb_hwregs_uart_multi;

  localparam int N = 2;
  localparam int D = 16;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           request = 1'b0;
  logic [15:0]    address = 16'h0;
  logic           write = 1'b0;
  logic [3:0]     wstrb = 4'h0;
  logic [31:0]    wdata = 32'h0;
  logic [31:0]    rdata;
  logic           ack;
  logic [N-1:0]   uart_rx_complete = '0;
  logic [8*N-1:0] uart_rx_data = '0;
  logic [N-1:0]   uart_tx_valid;
  logic [8*N-1:0] uart_tx_data;
  logic [N-1:0]   uart_tx_complete = '0;
  logic           irq;

  hwregs_uart_multi #(.NUM_UARTS(N), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .request(request), .address(address),
    .write(write), .wstrb(wstrb), .wdata(wdata), .rdata(rdata), .ack(ack),
    .uart_rx_complete(uart_rx_complete), .uart_rx_data(uart_rx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
    .uart_tx_complete(uart_tx_complete), .irq(irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  string       name_q [$];
  logic [31:0] mon_exp;
  string       mon_name;

  // Scoreboard monitor: one line per bus transaction.
  always @(negedge clock) begin
    if (reset_n) begin
      checks++;
      if (ack) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_ack rdata=%h required no ack", rdata);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_name = name_q.pop_front();
          if (rdata !== mon_exp) begin
            errors++;
            $display("FAIL %s rdata=%h required %h", mon_name, rdata, mon_exp);
          end else begin
            $display("ok   %s rdata=%h", mon_name, rdata);
          end
        end
      end else if (rdata !== 32'h0) begin
        errors++;
        $display("FAIL idle_rdata rdata=%h required 00000000", rdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- drivers
  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    request = 1'b1; write = 1'b1; address = a; wdata = d; wstrb = s;
    exp_q.push_back(32'h0);
    name_q.push_back($sformatf("wr_%h_%h", a, d));
    @(posedge clock); #1;
    request = 1'b0; write = 1'b0; wstrb = 4'h0; wdata = 32'h0;
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [31:0] e, input string nm);
    request = 1'b1; write = 1'b0; address = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock); #1;
    request = 1'b0;
  endtask

  task automatic pulse_rx(input int ch, input logic [7:0] b);
    uart_rx_complete[ch] = 1'b1;
    uart_rx_data[8*ch +: 8] = b;
    @(posedge clock); #1;
    uart_rx_complete[ch] = 1'b0;
  endtask

  task automatic pulse_tx(input int ch);
    uart_tx_complete[ch] = 1'b1;
    @(posedge clock); #1;
    uart_tx_complete[ch] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    bus_wr(16'h010C, 32'h1, 4'h1);     // ch0 IRQ_EN = rx_not_empty
    pulse_rx(0, 8'h99);
    bus_wr(16'h0100, 32'h33, 4'h1);
    idle(2);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b required 1", irq); end
    checks++;
    if (uart_tx_valid !== 2'b01) begin errors++; $display("FAIL pre_reset_tx_valid got %b required 01", uart_tx_valid); end
    // Assert reset in the middle of a read request.
    request = 1'b1; write = 1'b0; address = 16'h0104;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b required 0", ack); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b required 0", irq); end
    checks++;
    if (uart_tx_valid !== 2'b00) begin errors++; $display("FAIL reset_tx_valid got %b required 00", uart_tx_valid); end
    checks++;
    if (uart_tx_data !== 16'h0) begin errors++; $display("FAIL reset_tx_data got %h required 0000", uart_tx_data); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h required 00000000", rdata); end
    request = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(1);
    bus_rd(16'h0108, 32'h0000_0008, "ch0_status_after_reset");
    bus_rd(16'h010C, 32'h0, "ch0_irq_en_after_reset");
    bus_rd(16'h0000, 32'h0, "irq_status_after_reset");
    bus_rd(16'h0104, 32'hFFFF_FFFF, "ch0_rx_after_reset");
    bus_rd(16'h0100, 32'd16, "ch0_tx_free_after_reset");
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL post_reset_irq got %b required 0", irq); end
  endtask

  task automatic test_tx;
    bus_wr(16'h0110, 32'h41, 4'h0);    // no byte-0 strobe: ignored
    checks++;
    if (uart_tx_valid[1] !== 1'b0) begin errors++; $display("FAIL tx_nostrobe_valid got %b required 0", uart_tx_valid[1]); end
    bus_wr(16'h0110, 32'h41, 4'h1);
    bus_wr(16'h0110, 32'h1234_5642, 4'hF);
    checks++;
    if (uart_tx_valid !== 2'b10) begin errors++; $display("FAIL tx_valid got %b required 10", uart_tx_valid); end
    checks++;
    if (uart_tx_data[15:8] !== 8'h41) begin errors++; $display("FAIL tx_head1 got %h required 41", uart_tx_data[15:8]); end
    bus_rd(16'h0110, 32'd14, "ch1_tx_free_two_queued");
    pulse_tx(1);
    checks++;
    if (uart_tx_valid[1] !== 1'b1 || uart_tx_data[15:8] !== 8'h42) begin
      errors++; $display("FAIL tx_head2 valid=%b data=%h required 1/42", uart_tx_valid[1], uart_tx_data[15:8]);
    end
    pulse_tx(1);
    checks++;
    if (uart_tx_valid[1] !== 1'b0) begin errors++; $display("FAIL tx_drained_valid got %b required 0", uart_tx_valid[1]); end
    pulse_tx(1);                       // pop on empty: ignored
    bus_rd(16'h0110, 32'd16, "ch1_tx_free_empty");
    bus_rd(16'h0118, 32'h0000_0008, "ch1_status_after_tx");
  endtask

  task automatic test_rx;
    pulse_rx(0, 8'h55);
    bus_rd(16'h0104, 32'h0000_0055, "ch0_rx_byte");
    bus_rd(16'h0104, 32'hFFFF_FFFF, "ch0_rx_empty");
  endtask

  task automatic test_rx_overflow;
    for (int i = 0; i < 17; i++) pulse_rx(0, 8'(8'h10 + i));
    bus_rd(16'h0108, 32'h0010_000D, "ch0_status_rx_overflow");
    bus_wr(16'h0108, 32'h4, 4'h1);
    bus_rd(16'h0108, 32'h0010_0009, "ch0_status_after_w1c");
  endtask

  task automatic test_back_to_back;
    // Full FIFO: CPU pop and UART byte in the same cycle.
    request = 1'b1; write = 1'b0; address = 16'h0104;
    uart_rx_complete[0] = 1'b1; uart_rx_data[7:0] = 8'hAA;
    exp_q.push_back(32'h10);
    name_q.push_back("ch0_rx_pop_with_push");
    @(posedge clock); #1;
    request = 1'b0; uart_rx_complete[0] = 1'b0;
    bus_rd(16'h0108, 32'h0010_0009, "ch0_status_full_no_ovf");
    for (int i = 1; i < 16; i++) bus_rd(16'h0104, 32'(8'h10 + i), $sformatf("ch0_rx_b2b_%0d", i));
    bus_rd(16'h0104, 32'h0000_00AA, "ch0_rx_last_is_new");
    bus_rd(16'h0104, 32'hFFFF_FFFF, "ch0_rx_empty_after_drain");
  endtask

  task automatic test_irq;
    bus_wr(16'h011C, 32'h1, 4'h1);
    bus_rd(16'h011C, 32'h1, "ch1_irq_en_readback");
    idle(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b required 0", irq); end
    pulse_rx(1, 8'h77);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b required 0", irq); end
    idle(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b required 1", irq); end
    bus_rd(16'h0000, 32'h2, "irq_status_ch1");
    bus_rd(16'h0114, 32'h77, "ch1_rx_byte");
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold_one_cycle got %b required 1", irq); end
    idle(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b required 0", irq); end
    bus_rd(16'h0000, 32'h0, "irq_status_clear");
  endtask

  task automatic test_tx_overflow;
    for (int i = 0; i < 17; i++) bus_wr(16'h0100, 32'(8'hA0 + i), 4'h1);
    bus_rd(16'h0100, 32'h0, "ch0_tx_free_full");
    bus_rd(16'h0108, 32'h0000_0012, "ch0_status_tx_overflow");
    bus_wr(16'h0108, 32'h10, 4'h2);    // no byte-0 strobe: no clear
    bus_rd(16'h0108, 32'h0000_0012, "ch0_status_w1c_nostrobe");
    bus_wr(16'h0108, 32'h10, 4'h1);
    bus_rd(16'h0108, 32'h0000_0002, "ch0_status_tx_w1c");
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (uart_tx_valid[0] !== 1'b1 || uart_tx_data[7:0] !== 8'(8'hA0 + i)) begin
        errors++;
        $display("FAIL tx_drain_%0d valid=%b data=%h required 1/%h", i, uart_tx_valid[0], uart_tx_data[7:0], 8'(8'hA0 + i));
      end
      pulse_tx(0);
    end
    checks++;
    if (uart_tx_valid[0] !== 1'b0) begin errors++; $display("FAIL tx_drain_end valid=%b required 0", uart_tx_valid[0]); end
  endtask

  task automatic test_unmapped;
    bus_wr(16'h0120, 32'h5, 4'h1);     // channel 2 does not exist
    bus_rd(16'h0120, 32'h0, "unmapped_ch2_tx");
    bus_rd(16'h012C, 32'h0, "unmapped_ch2_irq_en");
    bus_rd(16'h0004, 32'h0, "unmapped_global");
    bus_rd(16'h0200, 32'h0, "unmapped_page");
    bus_rd(16'h0100, 32'd16, "ch0_tx_unaffected");
    bus_rd(16'h0110, 32'd16, "ch1_tx_unaffected");
  endtask

  initial begin
    idle(2);
    reset_n = 1'b1;
    idle(1);
    test_reset();
    test_tx();
    test_rx();
    test_rx_overflow();
    test_back_to_back();
    test_irq();
    test_tx_overflow();
    test_unmapped();
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_acks outstanding=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
